query_row_dbuf: RTL and testbench

- Ping-pong (double-buffered) row store for query patch data.
- Sits between the stream aggregator (write side) and the downstream patch-matching datapath (read side).
- One bank fills from the incoming stream while the other bank is randomly readable.
- Banks swap automatically when the fill bank has received DEPTH words.

---
 rtl/query_row_dbuf.sv | 67 ++++++
 tb/tb_query_row_dbuf.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/query_row_dbuf.sv
// Ping-pong row store for query patch data: one bank fills from the stream
// while the other is randomly readable; banks swap after DEPTH writes.
module query_row_dbuf #(
  parameter int DATA_WIDTH = 11,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fsm_enable,
  input  logic                  sender_enable,
  input  logic [DATA_WIDTH-1:0] sender_data,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] radr,
  output logic [DATA_WIDTH-1:0] receiver_data
);

  localparam logic [ADDR_WIDTH-1:0] WPTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [31:0]           DEPTH_W   = 32'(DEPTH);

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  logic                  wsel;
  logic [ADDR_WIDTH-1:0] wptr;
  logic                  wr_en;
  logic                  radr_ok;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_en   = fsm_enable && sender_enable;
  assign radr_ok = 32'(radr) < DEPTH_W;

  // Write-side state: the last word of a bank toggles wsel on the same edge
  // it is stored, so the next write lands at address 0 of the other bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel <= 1'b0;
      wptr <= '0;
    end else if (wr_en) begin
      if (wptr == WPTR_LAST) begin
        wptr <= '0;
        wsel <= ~wsel;
      end else begin
        wptr <= wptr + 1'b1;
      end
    end
  end

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wsel) mem1[wptr] <= sender_data;
      else      mem0[wptr] <= sender_data;
    end
  end

  always_comb begin
    rd_word = '0;
    if (radr_ok) rd_word = wsel ? mem0[radr] : mem1[radr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   receiver_data <= '0;
    else if (ren) receiver_data <= rd_word;
  end

endmodule

// File: tb/tb_query_row_dbuf.sv
// Scoreboard bench for query_row_dbuf: directed fill/swap/ping-pong/gating/
// hold/reset vectors on a 128-deep instance plus a 100-deep out-of-range one.
module tb_query_row_dbuf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fsm_enable = 1'b0;
  logic        fsm_enable_b = 1'b0;
  logic        sender_enable = 1'b0;
  logic [10:0] sender_data = '0;
  logic        ren = 1'b0;
  logic [6:0]  radr = '0;
  logic [10:0] receiver_data;
  logic [10:0] receiver_data_b;
  logic        chk_a = 1'b0;
  logic        chk_b = 1'b0;

  typedef struct {
    int    exp;
    string name;
  } sb_entry_t;

  sb_entry_t q_a[$];
  sb_entry_t q_b[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  query_row_dbuf #(.DATA_WIDTH(11), .ADDR_WIDTH(7), .DEPTH(128)) dut (
    .clk(clk), .rst_n(rst_n), .fsm_enable(fsm_enable),
    .sender_enable(sender_enable), .sender_data(sender_data),
    .ren(ren), .radr(radr), .receiver_data(receiver_data)
  );

  query_row_dbuf #(.DATA_WIDTH(11), .ADDR_WIDTH(7), .DEPTH(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .fsm_enable(fsm_enable_b),
    .sender_enable(sender_enable), .sender_data(sender_data),
    .ren(ren), .radr(radr), .receiver_data(receiver_data_b)
  );

  // Monitor: a check requested at an edge is compared at the following negedge.
  initial begin
    logic pa, pb;
    sb_entry_t e;
    forever begin
      @(posedge clk);
      pa = chk_a;
      pb = chk_b;
      @(negedge clk);
      if (pa) begin
        n_tests++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_underflow: got %0d, required a queued expectation", receiver_data);
        end else begin
          e = q_a.pop_front();
          if (int'(receiver_data) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", e.name, receiver_data, e.exp);
          end
        end
      end
      if (pb) begin
        n_tests++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b_underflow: got %0d, required a queued expectation", receiver_data_b);
        end else begin
          e = q_b.pop_front();
          if (int'(receiver_data_b) !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", e.name, receiver_data_b, e.exp);
          end
        end
      end
    end
  end

  task automatic step(input logic f, input logic fb, input logic se, input int d,
                      input logic r, input int a, input logic ca, input logic cb,
                      input int e, input string nm);
    @(negedge clk);
    fsm_enable    = f;
    fsm_enable_b  = fb;
    sender_enable = se;
    sender_data   = 11'(d);
    ren           = r;
    radr          = 7'(a);
    chk_a         = ca;
    chk_b         = cb;
    if (ca) q_a.push_back('{e, nm});
    if (cb) q_b.push_back('{e, nm});
  endtask

  task automatic wr(input int d);
    step(1'b1, 1'b0, 1'b1, d, 1'b0, 0, 1'b0, 1'b0, 0, "");
  endtask

  task automatic rd_a(input int a, input int e, input string nm);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, a, 1'b1, 1'b0, e, nm);
  endtask

  task automatic rd_b(input int a, input int e, input string nm);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, a, 1'b0, 1'b1, e, nm);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state: both outputs cleared.
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 0, "reset_out");

    // Fill bank0 with 0..127, then read it back after the swap.
    for (int i = 0; i < 128; i++) wr(i);
    rd_a(0, 0, "fill_r0");
    rd_a(5, 5, "fill_r5");
    rd_a(127, 127, "fill_r127");

    // Ping-pong: fill bank1 with 1000.. while reading bank0 every cycle.
    for (int i = 0; i < 128; i++)
      step(1'b1, 1'b0, 1'b1, 1000 + i, 1'b1, i, 1'b1, 1'b0, i, $sformatf("pp_r%0d", i));
    rd_a(3, 1003, "pp_new_r3");
    rd_a(127, 1127, "pp_new_r127");

    // Gapped and gated fill of bank0: 128 valid words, 999 strobes ignored.
    for (int k = 0; k < 128; k++) begin
      if (k % 7 == 3) step(1'b1, 1'b0, 1'b0, 999, 1'b0, 0, 1'b0, 1'b0, 0, "");
      if (k < 10)     step(1'b0, 1'b0, 1'b1, 999, 1'b0, 0, 1'b0, 1'b0, 0, "");
      wr(500 + k);
    end
    rd_a(0, 500, "gap_r0");
    rd_a(1, 501, "gap_r1");
    rd_a(9, 509, "gap_r9");
    rd_a(64, 564, "gap_r64");
    rd_a(127, 627, "gap_r127");

    // Read hold: ren low with a different address keeps the last word.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 0, 1'b0, i, 1'b1, 1'b0, 627, $sformatf("hold_%0d", i));

    // Mid-fill reset: 50 words into bank1, then an async pulse between edges.
    for (int i = 0; i < 50; i++) wr(1500 + i);
    idle();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (receiver_data !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got %0d, required 0", receiver_data);
    end
    #1 rst_n = 1'b1;
    // wsel back at 0, so reads see bank1 (partial new fill over old data).
    rd_a(0, 1500, "post_rst_r0");
    rd_a(60, 1060, "post_rst_r60");
    for (int i = 0; i < 127; i++) wr(1700 + i);
    rd_a(0, 1500, "no_early_swap");
    wr(1827);
    rd_a(0, 1700, "swap_r0");
    rd_a(127, 1827, "swap_r127");

    // Out-of-range reads on the 100-deep instance.
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b1, 1'b1, 200 + i, 1'b0, 0, 1'b0, 1'b0, 0, "");
    rd_b(7, 207, "b_r7");
    rd_b(99, 299, "b_r99");
    rd_b(120, 0, "b_oor120");
    rd_b(99, 299, "b_r99_again");
    rd_b(100, 0, "b_oor100");

    idle();
    idle();
    idle();
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
